// File: rtl/byte_fifo_4_pkg.sv
// Shared constants and types for the 4-entry byte FIFO.
package byte_fifo_4_pkg;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int CNT_W = 3;
    localparam int DATA_W = 8;

    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_UDF_BIT = 1;

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam cnt_t CNT_EMPTY = 3'd0;
    localparam cnt_t CNT_FULL  = 3'd4;

    // Pointer advance; the 2-bit width gives the 3 -> 0 wrap for free.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/dff_8bit.sv
// 8-bit enabled register used as one FIFO storage entry (no reset: contents are never observable while empty).
module dff_8bit (
    input  logic       clk,
    input  logic       en,
    input  logic [7:0] d,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Hold unless enabled.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end else begin
            q_d = q_q;
        end
    end

    // Storage register.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/byte_fifo_4.sv
// 4-entry show-ahead byte FIFO with occupancy count and status flags.
// Optional sticky overflow/underflow flags are built when BYTE_FIFO_ERR_EN is defined.
module byte_fifo_4
    import byte_fifo_4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] out,
    output logic       en,
    output logic       full,
    output logic       empty,
    output logic [2:0] count,
    output logic [1:0] err
);

    ptr_t             wr_ptr_q;
    ptr_t             wr_ptr_d;
    ptr_t             rd_ptr_q;
    ptr_t             rd_ptr_d;
    cnt_t             count_q;
    cnt_t             count_d;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic [DEPTH-1:0] wr_en_s;
    data_t            mem_s [DEPTH];

    assign full_s  = (count_q == CNT_FULL);
    assign empty_s = (count_q == CNT_EMPTY);

    // Acceptance: a pop frees the slot a full-FIFO push needs in the same cycle.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (push && (!full_s || pop)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
        if (pop && !empty_s) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
    end

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Write-pointer decode qualified by the accepted push.
    always_comb begin
        wr_en_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok_s && (wr_ptr_q == ptr_t'(i))) begin
                wr_en_s[i] = 1'b1;
            end else begin
                wr_en_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        dff_8bit u_entry (
            .clk (clk),
            .en  (wr_en_s[g]),
            .d   (in),
            .q   (mem_s[g])
        );
    end

    // Show-ahead read; forced to zero so stale storage never leaks out.
    always_comb begin
        out = 8'h00;
        if (empty_s) begin
            out = 8'h00;
        end else begin
            out = mem_s[rd_ptr_q];
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign en    = ~empty_s;
    assign count = count_q;

`ifdef BYTE_FIFO_ERR_EN
    logic [1:0] err_q;
    logic [1:0] err_d;

    // Sticky flags for rejected requests.
    always_comb begin
        err_d = err_q;
        if (push && !push_ok_s) begin
            err_d[ERR_OVF_BIT] = 1'b1;
        end else begin
            err_d[ERR_OVF_BIT] = err_q[ERR_OVF_BIT];
        end
        if (pop && !pop_ok_s) begin
            err_d[ERR_UDF_BIT] = 1'b1;
        end else begin
            err_d[ERR_UDF_BIT] = err_q[ERR_UDF_BIT];
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_byte_fifo_4.sv
// Self-checking bench for byte_fifo_4; expected err follows BYTE_FIFO_ERR_EN.
module tb_byte_fifo_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       push;
    logic       pop;
    logic [7:0] dout;
    logic       en;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic [1:0] err;

    logic [7:0] mq[$];
    logic [1:0] m_err;
    int         errors = 0;
    int         checks = 0;

`ifdef BYTE_FIFO_ERR_EN
    localparam logic [1:0] OVF_ERR = 2'b01;
    localparam logic [1:0] UDF_ERR = 2'b10;
`else
    localparam logic [1:0] OVF_ERR = 2'b00;
    localparam logic [1:0] UDF_ERR = 2'b00;
`endif

    always #5 clk = ~clk;

    byte_fifo_4 dut (
        .clk   (clk),
        .rst   (rst),
        .in    (din),
        .push  (push),
        .pop   (pop),
        .out   (dout),
        .en    (en),
        .full  (full),
        .empty (empty),
        .count (count),
        .err   (err)
    );

    // One clock with the given inputs; model follows the FIFO rules, not the RTL.
    task automatic cycle(input logic r, input logic p, input logic q, input logic [7:0] d);
        bit m_full;
        bit m_empty;
        bit push_acc;
        bit pop_acc;
        rst = r; push = p; pop = q; din = d;
        m_full   = (mq.size() == 4);
        m_empty  = (mq.size() == 0);
        push_acc = p && (!m_full || q);
        pop_acc  = q && !m_empty;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_err = 2'b00;
        end else begin
            if (pop_acc) void'(mq.pop_front());
            if (push_acc) mq.push_back(d);
`ifdef BYTE_FIFO_ERR_EN
            if (p && !push_acc) m_err[0] = 1'b1;
            if (q && !pop_acc) m_err[1] = 1'b1;
`endif
        end
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 8'h55);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", en); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", dout); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", err); end
    endtask

    task automatic test_single_push();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'hA1);
        checks++; if (dout !== 8'hA1) begin errors++; $display("FAIL single_out: got %h want a1", dout); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
        checks++; if (en !== 1'b1) begin errors++; $display("FAIL single_en: got %b want 1", en); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty: got %b want 0", empty); end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count4: got %0d want 4", count); end
        cycle(1'b0, 1'b1, 1'b0, 8'h05);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count_hold: got %0d want 4", count); end
        checks++; if (dout !== 8'h01) begin errors++; $display("FAIL ovf_out: got %h want 01", dout); end
        checks++; if (err !== OVF_ERR) begin errors++; $display("FAIL ovf_err: got %b want %b", err, OVF_ERR); end
    endtask

    // Continues from the full 01..04 state left by test_overflow.
    task automatic test_full_push_pop();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h02, 8'h03, 8'h04, 8'h05};
        cycle(1'b0, 1'b1, 1'b1, 8'h05);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fpp_count: got %0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dout !== exp_seq[i]) begin errors++; $display("FAIL fpp_pop%0d: got %h want %h", i, dout, exp_seq[i]); end
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fpp_empty: got %b want 1", empty); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL fpp_out0: got %h want 00", dout); end
    endtask

    task automatic test_empty_pop();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL epop_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL epop_empty: got %b want 1", empty); end
        checks++; if (err !== UDF_ERR) begin errors++; $display("FAIL epop_err: got %b want %b", err, UDF_ERR); end
        cycle(1'b0, 1'b1, 1'b1, 8'h3C);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL epp_count: got %0d want 1", count); end
        checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL epp_out: got %h want 3c", dout); end
    endtask

    task automatic test_reset_midop();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h70 + 8'(i));
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h11);
        cycle(1'b0, 1'b1, 1'b0, 8'h22);
        cycle(1'b0, 1'b1, 1'b0, 8'h33);
        cycle(1'b1, 1'b1, 1'b0, 8'h77);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b want 1", empty); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rmid_out: got %h want 00", dout); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL rmid_err: got %b want 00", err); end
    endtask

    task automatic test_random();
        logic [7:0] exp_out;
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 55),
                  ($urandom_range(0, 99) < 45), 8'($urandom));
            exp_out = (mq.size() != 0) ? mq[0] : 8'h00;
            checks++; if (count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, count, mq.size()); end
            checks++; if (dout !== exp_out) begin errors++; $display("FAIL rnd_out@%0d: got %h want %h", n, dout, exp_out); end
            checks++; if (full !== (mq.size() == 4)) begin errors++; $display("FAIL rnd_full@%0d: got %b", n, full); end
            checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty@%0d: got %b", n, empty); end
            checks++; if (en !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_en@%0d: got %b", n, en); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err@%0d: got %b want %b", n, err, m_err); end
        end
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; din = 8'h00; m_err = 2'b00;
        test_reset();
        test_single_push();
        test_overflow();
        test_full_push_pop();
        test_empty_pop();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/byte_fifo_4.md
BYTE_FIFO_4 -- requirements
Module: byte_fifo_4

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single rising-edge clock.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-003 The block SHALL have the port in, input, 8 bits: write data.
REQ-004 The block SHALL have the port push, input, 1 bit: write request.
REQ-005 The block SHALL have the port pop, input, 1 bit: read request.
REQ-006 The block SHALL have the port out, output, 8 bits: head-of-queue data (show-ahead).
REQ-007 The block SHALL have the port en, output, 1 bit: high when out is valid (not empty); drives the enable of the downstream 8-bit holding register.
REQ-008 The block SHALL have the port full, output, 1 bit: 4 entries held.
REQ-009 The block SHALL have the port empty, output, 1 bit: 0 entries held.
REQ-010 The block SHALL have the port count, output, 3 bits: occupancy, 0..4.
REQ-011 The block SHALL have the port err, output, 2 bits: sticky error flags, bit0 = overflow, bit1 = underflow.

Function
REQ-012 The block SHALL store 4 entries of 8 bits, using 2-bit read and write pointers that wrap from 3 to 0.
REQ-013 The out port SHALL equal the entry at the read pointer combinationally, with zero latency from the write to visibility once the entry is registered (1 clk after push).
REQ-014 The out port SHALL be 8'h00 whenever empty=1.
REQ-015 A push SHALL be accepted when full=0, or when full=1 and pop=1 in the same cycle; on acceptance, in is written at the write pointer and the write pointer increments.
REQ-016 A pop SHALL be accepted when empty=0; on acceptance, the read pointer increments.
REQ-017 A push with pop while empty SHALL accept the push only and reject the pop.
REQ-018 Simultaneous accepted push and pop SHALL leave count unchanged.
REQ-019 Otherwise, count SHALL be +1 on an accepted push and -1 on an accepted pop.
REQ-020 The flags SHALL be derived as full = (count==4), empty = (count==0), en = ~empty; all are registered-state derived, with no combinational path from push or pop.
REQ-021 A rejected push SHALL leave storage and pointers unchanged.
REQ-022 A rejected pop SHALL leave storage and pointers unchanged.

Reset
REQ-023 When rst=1 at a clock edge, the pointers SHALL be set to 0, count to 0, empty to 1, full to 0, en to 0, out to 8'h00, and err to 2'b00.
REQ-024 Reset SHALL take priority over push and pop in the same cycle.
REQ-025 Storage contents after reset SHALL be don't-care and never observable.
REQ-026 Reset asserted mid-operation SHALL discard all held entries.

Configuration
REQ-027 When macro BYTE_FIFO_ERR_EN is defined, err[0] SHALL set on a rejected push and err[1] on a rejected pop, and both SHALL hold until rst.
REQ-028 When BYTE_FIFO_ERR_EN is undefined, err SHALL be constant 2'b00, the err port SHALL remain present, and the flag logic SHALL be absent.

Structure
REQ-029 The depth (4), pointer width (2), and count width (3) SHALL be constants in the shared project package.
REQ-030 The err bit indices SHALL be constants in the shared project package.
REQ-031 Each storage entry SHALL be one instance of the existing dff_8bit enabled register, with its enable driven by the write-pointer decode and the accepted push.

Verification
REQ-032 Reset, then push 8'hA1: on the next cycle, out=8'hA1, count=1, en=1, empty=0.
REQ-033 Push 8'h01..8'h04: full=1 and count=4; a further push of 8'h05 is rejected, out stays 8'h01, and with ERR_EN, err=2'b01.
REQ-034 While full, push 8'h05 with pop: count stays 4; subsequent pops yield 02, 03, 04, 05, exercising pointer wrap.
REQ-035 While empty, pop alone: no state change and, with ERR_EN, err=2'b10; while empty, push 8'h3C with pop: count=1 and out=8'h3C.
REQ-036 With 3 entries held, assert rst with push: next cycle count=0, empty=1, out=8'h00, err=2'b00.
REQ-037 The bench SHALL run with and without BYTE_FIFO_ERR_EN; without it, err SHALL equal 2'b00 in all scenarios.
